// File: rtl/matmul2x2_fp32.sv
`default_nettype none
// ============================================================================
// Module      : matmul2x2_fp32
// Description : 2x2 FP32 matrix multiply C = A x B behind a four-phase
//               handshake. Eight products are registered in MUL; the four sums
//               are registered in ADD and then presented with output_Stable.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul2x2_fp32 (
  input  logic        input_Clk,
  input  logic        input_Reset,
  input  logic        input_Stable,
  input  logic        input_C_Ack,
  input  logic [31:0] input_A11,
  input  logic [31:0] input_A12,
  input  logic [31:0] input_A21,
  input  logic [31:0] input_A22,
  input  logic [31:0] input_B11,
  input  logic [31:0] input_B12,
  input  logic [31:0] input_B21,
  input  logic [31:0] input_B22,
  output logic        output_AB_Ack,
  output logic        output_Stable,
  output logic [31:0] output_C11,
  output logic [31:0] output_C12,
  output logic [31:0] output_C21,
  output logic [31:0] output_C22
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  // ADD spends two cycles: the first registers the sums, the second drives
  // the outputs, which fixes the request-to-result latency at three edges.
  logic        add_phase;
  logic [31:0] a_q    [4];
  logic [31:0] b_q    [4];
  logic [31:0] prod_q [8];
  logic [31:0] sum_q  [4];

  // Round-to-nearest-even on a normalised 24-bit mantissa, then pack with
  // overflow to infinity and underflow flushed to signed zero.
  function automatic logic [31:0] fp_round_pack(input logic sign,
                                                input logic signed [10:0] exp_in,
                                                input logic [23:0] mant,
                                                input logic guard,
                                                input logic sticky);
    logic [24:0]        m;
    logic signed [10:0] e;
    m = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
    e = exp_in;
    if (m[24]) begin
      m = m >> 1;
      e = e + 11'sd1;
    end
    if (e >= 11'sd255) return {sign, 8'hFF, 23'd0};
    if (e <= 11'sd0)   return {sign, 31'd0};
    return {sign, e[7:0], m[22:0]};
  endfunction

  // FP32 multiply; Inf/NaN inputs yield signed infinity, zero/denormal give signed zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic               sign;
    logic [47:0]        p;
    logic signed [10:0] e;
    sign = x[31] ^ y[31];
    p    = {1'b1, x[22:0]} * {1'b1, y[22:0]};
    e    = $signed({3'b0, x[30:23]}) + $signed({3'b0, y[30:23]}) - 11'sd127;
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return {sign, 8'hFF, 23'd0};
    if (x[30:23] == 8'd0  || y[30:23] == 8'd0)  return {sign, 31'd0};
    if (p[47]) return fp_round_pack(sign, e + 11'sd1, p[47:24], p[23], |p[22:0]);
    return fp_round_pack(sign, e, p[46:23], p[22], |p[21:0]);
  endfunction

  // FP32 add: align the smaller magnitude with guard/round/sticky bits, add or
  // subtract, renormalise, round. An exact zero result is +0.
  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0]        hi, lo;
    logic [7:0]         diff;
    logic [49:0]        shifted;
    logic [27:0]        mb, ms, s;
    logic signed [10:0] e;
    if (x[30:23] == 8'hFF) return {x[31], 8'hFF, 23'd0};
    if (y[30:23] == 8'hFF) return {y[31], 8'hFF, 23'd0};
    if (y[30:23] == 8'd0)  return (x[30:23] == 8'd0) ? 32'd0 : x;
    if (x[30:23] == 8'd0)  return y;
    if (x[30:0] >= y[30:0]) begin
      hi = x;
      lo = y;
    end else begin
      hi = y;
      lo = x;
    end
    diff    = hi[30:23] - lo[30:23];
    shifted = {1'b1, lo[22:0], 26'd0} >> ((diff > 8'd49) ? 8'd49 : diff);
    mb      = {1'b0, 1'b1, hi[22:0], 3'd0};
    ms      = {1'b0, shifted[49:24], shifted[23] | (|shifted[22:0])};
    s       = (hi[31] == lo[31]) ? (mb + ms) : (mb - ms);
    e       = $signed({3'b0, hi[30:23]});
    if (s == 28'd0) return 32'd0;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 11'sd1;
    end else begin
      // Left shifts only lose information when alignment was at most one
      // place, in which case the low bits are still exact.
      for (int i = 0; i < 27; i++) begin
        if (!s[26]) begin
          s = s << 1;
          e = e - 11'sd1;
        end
      end
    end
    return fp_round_pack(hi[31], e, s[26:3], s[2], s[1] | s[0]);
  endfunction

  // Handshake FSM with operand, product, sum and output registers.
  always_ff @(posedge input_Clk or negedge input_Reset) begin
    if (!input_Reset) begin
      state         <= IDLE;
      add_phase     <= 1'b0;
      output_AB_Ack <= 1'b0;
      output_Stable <= 1'b0;
      output_C11    <= 32'd0;
      output_C12    <= 32'd0;
      output_C21    <= 32'd0;
      output_C22    <= 32'd0;
      a_q           <= '{default: 32'd0};
      b_q           <= '{default: 32'd0};
      prod_q        <= '{default: 32'd0};
      sum_q         <= '{default: 32'd0};
    end else begin
      output_AB_Ack <= 1'b0;
      case (state)
        IDLE: begin
          if (input_Stable) begin
            a_q           <= '{input_A11, input_A12, input_A21, input_A22};
            b_q           <= '{input_B11, input_B12, input_B21, input_B22};
            output_AB_Ack <= 1'b1;
            state         <= MUL;
          end
        end
        MUL: begin
          prod_q[0] <= fp_mul(a_q[0], b_q[0]);
          prod_q[1] <= fp_mul(a_q[1], b_q[2]);
          prod_q[2] <= fp_mul(a_q[0], b_q[1]);
          prod_q[3] <= fp_mul(a_q[1], b_q[3]);
          prod_q[4] <= fp_mul(a_q[2], b_q[0]);
          prod_q[5] <= fp_mul(a_q[3], b_q[2]);
          prod_q[6] <= fp_mul(a_q[2], b_q[1]);
          prod_q[7] <= fp_mul(a_q[3], b_q[3]);
          state     <= ADD;
        end
        ADD: begin
          if (!add_phase) begin
            sum_q[0]  <= fp_add(prod_q[0], prod_q[1]);
            sum_q[1]  <= fp_add(prod_q[2], prod_q[3]);
            sum_q[2]  <= fp_add(prod_q[4], prod_q[5]);
            sum_q[3]  <= fp_add(prod_q[6], prod_q[7]);
            add_phase <= 1'b1;
          end else begin
            output_C11    <= sum_q[0];
            output_C12    <= sum_q[1];
            output_C21    <= sum_q[2];
            output_C22    <= sum_q[3];
            output_Stable <= 1'b1;
            add_phase     <= 1'b0;
            state         <= DONE;
          end
        end
        DONE: begin
          if (input_C_Ack) begin
            output_Stable <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul2x2_fp32.sv
`default_nettype none
// ============================================================================
// Module      : tb_matmul2x2_fp32
// Description : Scoreboard bench for matmul2x2_fp32 with a real-arithmetic
//               FP32 reference model and randomized operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul2x2_fp32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0;
  logic        c_ack = 1'b0;
  logic [31:0] a [4];
  logic [31:0] b [4];
  logic        ab_ack, out_stb;
  logic [31:0] c11, c12, c21, c22;

  int          errors = 0;
  int          checks = 0;
  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  matmul2x2_fp32 dut (
    .input_Clk     (clk),
    .input_Reset   (rst_n),
    .input_Stable  (stb),
    .input_C_Ack   (c_ack),
    .input_A11     (a[0]),
    .input_A12     (a[1]),
    .input_A21     (a[2]),
    .input_A22     (a[3]),
    .input_B11     (b[0]),
    .input_B12     (b[1]),
    .input_B21     (b[2]),
    .input_B22     (b[3]),
    .output_AB_Ack (ab_ack),
    .output_Stable (out_stb),
    .output_C11    (c11),
    .output_C12    (c12),
    .output_C21    (c21),
    .output_C22    (c22)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // FP32 bit pattern to real (denormals read as zero).
  function automatic real to_real(input logic [31:0] x);
    real v;
    int  e;
    if (x[30:23] == 8'd0) return 0.0;
    v = 1.0 + real'(x[22:0]) / 8388608.0;
    e = int'(x[30:23]) - 127;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return x[31] ? -v : v;
  endfunction

  // Real to FP32, round to nearest even, overflow to Inf, underflow to zero.
  function automatic logic [31:0] to_fp32(input real r);
    real    m, fl;
    int     e;
    logic   sgn;
    longint mant;
    if (r == 0.0) return 32'd0;
    sgn = (r < 0.0);
    m   = sgn ? -r : r;
    e   = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    m    = m * 8388608.0;
    fl   = $floor(m);
    mant = longint'(fl);
    if ((m - fl) > 0.5 || ((m - fl) == 0.5 && mant[0])) mant++;
    if (mant == 64'd16777216) begin
      mant = 64'd8388608;
      e++;
    end
    e = e + 127;
    if (e >= 255) return {sgn, 8'hFF, 23'd0};
    if (e <= 0)   return {sgn, 31'd0};
    return {sgn, e[7:0], mant[22:0]};
  endfunction

  function automatic logic [31:0] rmul(input logic [31:0] x, input logic [31:0] y);
    return to_fp32(to_real(x) * to_real(y));
  endfunction

  function automatic logic [31:0] radd(input logic [31:0] x, input logic [31:0] y);
    return to_fp32(to_real(x) + to_real(y));
  endfunction

  // Each C element: two individually rounded products, then a rounded sum.
  function automatic logic [127:0] model();
    logic [31:0] r [4];
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        r[2*i+j] = radd(rmul(a[2*i], b[j]), rmul(a[2*i+1], b[2+j]));
    return {r[0], r[1], r[2], r[3]};
  endfunction

  // Operands with exponents kept close so every sum is exact in double.
  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = 8'($urandom_range(134, 120));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic randomize_ops();
    for (int i = 0; i < 4; i++) begin
      a[i] = rand_fp();
      b[i] = rand_fp();
    end
  endtask

  // Monitor: compare every newly presented result with the scoreboard head.
  always @(negedge clk) begin : monitor
    logic [127:0] ex;
    logic         prev;
    if (out_stb && !prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h, expected no result", c11);
      end else begin
        ex = exp_q.pop_front();
        check("C11", c11, ex[127:96]);
        check("C12", c12, ex[95:64]);
        check("C21", c21, ex[63:32]);
        check("C22", c22, ex[31:0]);
      end
    end
    prev = out_stb;
  end

  // One full transaction with fixed-latency and handshake checks.
  task automatic run_op(input logic [127:0] expected, input bit scramble, input bit hold_stb);
    exp_q.push_back(expected);
    stb = 1'b1;
    @(posedge clk); #1;
    check("ab_ack_pulse", 32'(ab_ack), 32'd1);
    if (scramble) begin
      randomize_ops();
      stb = 1'b0;
    end else if (!hold_stb) begin
      stb = 1'b0;
    end
    @(posedge clk); #1;
    check("ab_ack_one_cycle", 32'(ab_ack), 32'd0);
    check("stable_e1", 32'(out_stb), 32'd0);
    @(posedge clk); #1;
    check("stable_e2", 32'(out_stb), 32'd0);
    @(posedge clk); #1;
    check("stable_latency3", 32'(out_stb), 32'd1);
    repeat (2) begin
      @(posedge clk); #1;
      check("stable_held", 32'(out_stb), 32'd1);
      check("no_ack_in_done", 32'(ab_ack), 32'd0);
    end
    stb   = 1'b0;
    c_ack = 1'b1;
    @(posedge clk); #1;
    c_ack = 1'b0;
    check("stable_released", 32'(out_stb), 32'd0);
    check("c11_kept", c11, expected[127:96]);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      a[i] = 32'd0;
      b[i] = 32'd0;
    end
    // Reset held low while a request is offered
    randomize_ops();
    stb = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_ab_ack", 32'(ab_ack), 32'd0);
      check("rst_stable", 32'(out_stb), 32'd0);
    end
    check("rst_c11", c11, 32'd0);
    check("rst_c22", c22, 32'd0);
    stb   = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // A = B = [3 6; 4 5], input_Stable kept high through DONE
    a = '{to_fp32(3.0), to_fp32(6.0), to_fp32(4.0), to_fp32(5.0)};
    b = '{to_fp32(3.0), to_fp32(6.0), to_fp32(4.0), to_fp32(5.0)};
    run_op({32'h42040000, 32'h42400000, 32'h42000000, 32'h42440000}, 1'b0, 1'b1);

    // New operands with input_Stable low: no handshake
    randomize_ops();
    repeat (3) begin
      @(posedge clk); #1;
      check("idle_no_ack", 32'(ab_ack), 32'd0);
      check("idle_no_stable", 32'(out_stb), 32'd0);
    end

    // Mixed-sign exact case
    a = '{to_fp32(-3.25), to_fp32(-0.75), to_fp32(17.75), to_fp32(-21.75)};
    b = '{to_fp32(5.4375), to_fp32(43.0), to_fp32(1.96875), to_fp32(1.5)};
    run_op({to_fp32(-19.1484375), to_fp32(-140.875), to_fp32(53.6953125), to_fp32(730.625)},
           1'b0, 1'b0);

    // Inputs changed and input_Stable dropped during MUL
    randomize_ops();
    run_op(model(), 1'b1, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 8; n++) begin
      randomize_ops();
      run_op(model(), 1'($urandom), 1'b0);
    end

    // Reach DONE, then reset asynchronously mid-cycle
    randomize_ops();
    exp_q.push_back(model());
    stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("pre_reset_stable", 32'(out_stb), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_stable", 32'(out_stb), 32'd0);
    check("async_rst_c11", c11, 32'd0);
    check("async_rst_c12", c12, 32'd0);
    check("async_rst_c21", c21, 32'd0);
    check("async_rst_c22", c22, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Large-magnitude case after reset release
    a = '{to_fp32(88064.0), to_fp32(30208.0), to_fp32(5574656.0), to_fp32(3836736.0)};
    b = '{to_fp32(6554112.0), to_fp32(-4456960.0), to_fp32(-153600.0), to_fp32(88064.0)};
    run_op(model(), 1'b0, 1'b0);
    check("c11_exact_large", c11, to_fp32(572541370368.0));

    repeat (2) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
